tetris_fall_ctrl: RTL and testbench

//  Sequences the falling piece inside the 10x20 well that sits right of the divider wall
//  (grid cols 7..16, rows 1..20; cell = 10x10 px). Turns gravity ticks and player move

---
 rtl/tetris_fall_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_tetris_fall_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_fall_ctrl.sv
// Falling-piece sequencer for the 10x20 well (grid cols 7..16, rows 1..20).
// Converts gravity ticks and player move pulses into candidate poses, hands
// each candidate to the external collision checker over a req/ack handshake,
// and commits, locks or spawns depending on the answer.
module tetris_fall_ctrl #(
    parameter int SPAWN_X     = 10,
    parameter int SPAWN_Y     = 1,
    parameter int GRAV_FRAMES = 30,
    parameter int GRAV_FAST   = 3,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       mv_left,
    input  logic       mv_right,
    input  logic       mv_rot,
    input  logic       hard_drop,
    input  logic       soft_drop,
    output logic       chk_req,
    output logic [4:0] chk_x,
    output logic [4:0] chk_y,
    output logic [1:0] chk_rot,
    input  logic       chk_ack,
    input  logic       chk_hit,
    output logic [4:0] piece_x,
    output logic [4:0] piece_y,
    output logic [1:0] piece_rot,
    output logic       lock_stb,
    input  logic       lock_done,
    output logic       spawn_stb,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_SPAWN   = 3'd0,
        S_IDLE    = 3'd1,
        S_CHECK   = 3'd2,
        S_DROP    = 3'd3,
        S_LOCK    = 3'd4,
        S_WAITCLR = 3'd5,
        S_OVER    = 3'd6
    } state_t;

    // What the outstanding single-shot check was issued for.
    typedef enum logic [1:0] {
        K_MOVE  = 2'd0,
        K_GRAV  = 2'd1,
        K_SPAWN = 2'd2
    } kind_t;

    localparam logic [CNT_W-1:0] LIM_NORM = CNT_W'(GRAV_FRAMES - 1);
    localparam logic [CNT_W-1:0] LIM_FAST = CNT_W'(GRAV_FAST - 1);
    localparam logic [4:0]       SPX      = 5'(SPAWN_X);
    localparam logic [4:0]       SPY      = 5'(SPAWN_Y);

    state_t           state;
    state_t           state_nxt;
    kind_t            kind;
    logic [CNT_W-1:0] grav_cnt;
    logic             grav_pend;
    logic [CNT_W-1:0] grav_lim;
    logic             grav_fire;

    logic ack_v;
    logic ev_drop;
    logic ev_rot;
    logic ev_left;
    logic ev_right;
    logic ev_grav;
    logic ev_any;
    logic spawn_ok;

    // An ack only counts while a request is actually outstanding.
    assign ack_v = chk_ack & chk_req;

    // One IDLE event per visit, strict priority; losers that cycle are dropped.
    assign ev_drop  = (state == S_IDLE) & hard_drop;
    assign ev_rot   = (state == S_IDLE) & ~hard_drop & mv_rot;
    assign ev_left  = (state == S_IDLE) & ~hard_drop & ~mv_rot & mv_left;
    assign ev_right = (state == S_IDLE) & ~hard_drop & ~mv_rot & ~mv_left & mv_right;
    assign ev_grav  = (state == S_IDLE) & ~hard_drop & ~mv_rot & ~mv_left & ~mv_right
                      & grav_pend;
    assign ev_any   = ev_drop | ev_rot | ev_left | ev_right | ev_grav;

    assign spawn_ok = (state == S_CHECK) & (kind == K_SPAWN) & ack_v & ~chk_hit;

    // ">=" also fires when soft_drop shrinks the limit below the running count.
    assign grav_lim  = soft_drop ? LIM_FAST : LIM_NORM;
    assign grav_fire = frame_tick & (state != S_OVER) & (grav_cnt >= grav_lim);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_SPAWN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_SPAWN: state_nxt = S_CHECK;
            S_IDLE: begin
                if (ev_drop) begin
                    state_nxt = S_DROP;
                end else if (ev_any) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (ack_v) begin
                    case (kind)
                        K_SPAWN: state_nxt = chk_hit ? S_OVER : S_IDLE;
                        K_GRAV:  state_nxt = chk_hit ? S_LOCK : S_IDLE;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_DROP: begin
                if (ack_v && chk_hit) begin
                    state_nxt = S_LOCK;
                end
            end
            S_LOCK:    state_nxt = S_WAITCLR;
            S_WAITCLR: begin
                if (lock_done) begin
                    state_nxt = S_SPAWN;
                end
            end
            S_OVER:    state_nxt = S_OVER;
            default:   state_nxt = S_SPAWN;
        endcase
    end

    // Strobes and status that follow directly from the current state.
    always_comb begin
        lock_stb  = (state == S_LOCK);
        game_over = (state == S_OVER);
    end

    // Gravity counter; a fresh spawn restarts the cadence and forgets any pending step.
    always_ff @(posedge clk) begin
        if (rst) begin
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else if (spawn_ok) begin
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else begin
            if (frame_tick && (state != S_OVER)) begin
                grav_cnt <= grav_fire ? '0 : grav_cnt + CNT_W'(1);
            end
            if (grav_fire) begin
                grav_pend <= 1'b1;
            end else if (ev_grav) begin
                grav_pend <= 1'b0;
            end
        end
    end

    // Candidate issue, handshake and pose commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_req   <= 1'b0;
            chk_x     <= SPX;
            chk_y     <= SPY;
            chk_rot   <= 2'd0;
            piece_x   <= SPX;
            piece_y   <= SPY;
            piece_rot <= 2'd0;
            kind      <= K_SPAWN;
            spawn_stb <= 1'b0;
        end else begin
            spawn_stb <= 1'b0;
            case (state)
                S_SPAWN: begin
                    chk_x   <= SPX;
                    chk_y   <= SPY;
                    chk_rot <= 2'd0;
                    chk_req <= 1'b1;
                    kind    <= K_SPAWN;
                end
                S_IDLE: begin
                    if (ev_any) begin
                        chk_req <= 1'b1;
                        chk_x   <= piece_x;
                        chk_y   <= piece_y;
                        chk_rot <= piece_rot;
                        kind    <= ev_grav ? K_GRAV : K_MOVE;
                        if (ev_drop || ev_grav) chk_y   <= piece_y + 5'd1;
                        if (ev_rot)             chk_rot <= piece_rot + 2'd1;
                        if (ev_left)            chk_x   <= piece_x - 5'd1;
                        if (ev_right)           chk_x   <= piece_x + 5'd1;
                    end
                end
                S_CHECK: begin
                    if (ack_v) begin
                        chk_req <= 1'b0;
                        if (!chk_hit) begin
                            piece_x   <= chk_x;
                            piece_y   <= chk_y;
                            piece_rot <= chk_rot;
                            if (kind == K_SPAWN) spawn_stb <= 1'b1;
                        end
                    end
                end
                S_DROP: begin
                    if (ack_v) begin
                        chk_req <= 1'b0;
                        if (!chk_hit) begin
                            piece_x   <= chk_x;
                            piece_y   <= chk_y;
                            piece_rot <= chk_rot;
                        end
                    end else if (!chk_req) begin
                        // Request is idle for one cycle between drop steps.
                        chk_req <= 1'b1;
                        chk_x   <= piece_x;
                        chk_y   <= piece_y + 5'd1;
                        chk_rot <= piece_rot;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_fall_ctrl.sv
// Self-checking bench for tetris_fall_ctrl: the bench acts as collision
// checker and board writer, keeps a behavioural model of the expected
// piece sequencing, compares every cycle, and pins key scenarios with literals.
module tb_tetris_fall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       mv_left = 1'b0;
    logic       mv_right = 1'b0;
    logic       mv_rot = 1'b0;
    logic       hard_drop = 1'b0;
    logic       soft_drop = 1'b0;
    logic       chk_ack = 1'b0;
    logic       chk_hit = 1'b0;
    logic       lock_done = 1'b0;
    logic       chk_req;
    logic [4:0] chk_x;
    logic [4:0] chk_y;
    logic [1:0] chk_rot;
    logic [4:0] piece_x;
    logic [4:0] piece_y;
    logic [1:0] piece_rot;
    logic       lock_stb;
    logic       spawn_stb;
    logic       game_over;

    always #5 clk = ~clk;

    tetris_fall_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .mv_left(mv_left), .mv_right(mv_right), .mv_rot(mv_rot),
        .hard_drop(hard_drop), .soft_drop(soft_drop),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_rot(chk_rot),
        .chk_ack(chk_ack), .chk_hit(chk_hit),
        .piece_x(piece_x), .piece_y(piece_y), .piece_rot(piece_rot),
        .lock_stb(lock_stb), .lock_done(lock_done),
        .spawn_stb(spawn_stb), .game_over(game_over)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- collision checker responder ----------------
    int hit_mode = 0;   // 0 never hit, 1 always hit, 2 walls only, 3 walls + random
    int lat_max  = 2;
    bit spur_en  = 0;
    int lat_cnt  = 0;

    function automatic bit wall_hit(input int x, input int y);
        return (x < 7) || (x > 16) || (y < 1) || (y > 20);
    endfunction

    always @(negedge clk) begin
        chk_ack = 1'b0;
        chk_hit = 1'b0;
        if (chk_req === 1'b1) begin
            if (lat_cnt <= 0) begin
                chk_ack = 1'b1;
                case (hit_mode)
                    0: chk_hit = 1'b0;
                    1: chk_hit = 1'b1;
                    2: chk_hit = wall_hit(int'(chk_x), int'(chk_y));
                    default: chk_hit = wall_hit(int'(chk_x), int'(chk_y))
                                       || ($urandom_range(0, 9) == 0);
                endcase
                lat_cnt = $urandom_range(0, lat_max);
            end else begin
                lat_cnt--;
            end
        end else if (spur_en && ($urandom_range(0, 15) == 0)) begin
            chk_ack = 1'b1;
            chk_hit = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- board writer responder ----------------
    bit auto_clr = 1;
    int clr_cnt  = -1;
    int man_req  = 0;
    int man_done = 0;

    always @(negedge clk) begin
        lock_done = 1'b0;
        if (man_req != man_done) begin
            lock_done = 1'b1;
            man_done  = man_req;
        end else if (auto_clr) begin
            if (lock_stb === 1'b1) begin
                clr_cnt = $urandom_range(0, 4);
            end else if (clr_cnt == 0) begin
                lock_done = 1'b1;
                clr_cnt   = -1;
            end else if (clr_cnt > 0) begin
                clr_cnt--;
            end
        end
    end

    // ---------------- behavioural model ----------------
    localparam int PH_SPAWN = 0, PH_IDLE = 1, PH_WAIT = 2, PH_DROP = 3,
                   PH_LOCK = 4, PH_CLR = 5, PH_OVER = 6;
    localparam int K_MOVE = 0, K_GRAV = 1, K_SPAWN = 2;

    bit m_valid = 0;
    int m_ph, m_kind, m_px, m_py, m_pr, m_cx, m_cy, m_cr, m_cnt;
    bit m_req, m_pend, m_spawn;

    always @(posedge clk) begin
        bit ackv, fire, consumed, spawned;
        int lim;
        if (rst) begin
            m_valid = 1; m_ph = PH_SPAWN; m_kind = K_SPAWN;
            m_px = 10; m_py = 1; m_pr = 0; m_cx = 10; m_cy = 1; m_cr = 0;
            m_req = 0; m_cnt = 0; m_pend = 0; m_spawn = 0;
        end else if (m_valid) begin
            ackv = (chk_ack === 1'b1) && m_req;
            fire = 0; consumed = 0; spawned = 0; m_spawn = 0;
            if (m_ph != PH_OVER && frame_tick) begin
                lim = soft_drop ? 3 : 30;
                if (m_cnt >= lim - 1) begin m_cnt = 0; fire = 1; end
                else m_cnt++;
            end
            case (m_ph)
                PH_SPAWN: begin
                    m_cx = 10; m_cy = 1; m_cr = 0; m_req = 1; m_kind = K_SPAWN; m_ph = PH_WAIT;
                end
                PH_IDLE: begin
                    if (hard_drop) begin
                        m_cx = m_px; m_cy = m_py + 1; m_cr = m_pr; m_req = 1; m_ph = PH_DROP;
                    end else if (mv_rot || mv_left || mv_right || m_pend) begin
                        m_cx = m_px; m_cy = m_py; m_cr = m_pr; m_kind = K_MOVE;
                        if (mv_rot)        m_cr = (m_pr + 1) % 4;
                        else if (mv_left)  m_cx = m_px - 1;
                        else if (mv_right) m_cx = m_px + 1;
                        else begin m_cy = m_py + 1; m_kind = K_GRAV; consumed = 1; end
                        m_req = 1; m_ph = PH_WAIT;
                    end
                end
                PH_WAIT: begin
                    if (ackv) begin
                        m_req = 0;
                        if (m_kind == K_SPAWN) begin
                            if (chk_hit) m_ph = PH_OVER;
                            else begin
                                m_px = 10; m_py = 1; m_pr = 0;
                                m_spawn = 1; spawned = 1; m_ph = PH_IDLE;
                            end
                        end else if (chk_hit) begin
                            m_ph = (m_kind == K_GRAV) ? PH_LOCK : PH_IDLE;
                        end else begin
                            m_px = m_cx; m_py = m_cy; m_pr = m_cr; m_ph = PH_IDLE;
                        end
                    end
                end
                PH_DROP: begin
                    if (ackv) begin
                        m_req = 0;
                        if (chk_hit) m_ph = PH_LOCK;
                        else m_py = m_cy;
                    end else if (!m_req) begin
                        m_cx = m_px; m_cy = m_py + 1; m_cr = m_pr; m_req = 1;
                    end
                end
                PH_LOCK: m_ph = PH_CLR;
                PH_CLR:  if (lock_done) m_ph = PH_SPAWN;
                default: ;
            endcase
            if (consumed) m_pend = 0;
            if (fire)     m_pend = 1;
            if (spawned) begin m_pend = 0; m_cnt = 0; end
        end
    end

    // ---------------- per-cycle compare and event counters ----------------
    int req_rises = 0, lock_pulses = 0, spawn_pulses = 0, y_steps = 0;
    int last_x = 0, last_y = 0, last_r = 0;
    bit prev_req = 0;
    int prev_py = 1;

    always @(negedge clk) begin
        if (m_valid) begin
            check_eq("chk_req", int'(chk_req), int'(m_req));
            if (m_req) begin
                check_eq("chk_x", int'(chk_x), m_cx);
                check_eq("chk_y", int'(chk_y), m_cy);
                check_eq("chk_rot", int'(chk_rot), m_cr);
            end
            check_eq("piece_x", int'(piece_x), m_px);
            check_eq("piece_y", int'(piece_y), m_py);
            check_eq("piece_rot", int'(piece_rot), m_pr);
            check_eq("lock_stb", int'(lock_stb), int'(m_ph == PH_LOCK));
            check_eq("spawn_stb", int'(spawn_stb), int'(m_spawn));
            check_eq("game_over", int'(game_over), int'(m_ph == PH_OVER));
        end
        if (chk_req === 1'b1 && !prev_req) begin
            req_rises++;
            last_x = int'(chk_x); last_y = int'(chk_y); last_r = int'(chk_rot);
        end
        prev_req = (chk_req === 1'b1);
        if (lock_stb === 1'b1)  lock_pulses++;
        if (spawn_stb === 1'b1) spawn_pulses++;
        if (int'(piece_y) != prev_py) y_steps++;
        prev_py = int'(piece_y);
    end

    // ---------------- directed helpers ----------------
    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1; step(2); rst = 1'b0;
    endtask

    task automatic wait_spawn(input string name);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step(1);
            if (spawn_stb === 1'b1) seen = 1;
        end
        check_eq(name, int'(seen), 1);
    endtask

    task automatic wait_lock(input string name);
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            step(1);
            if (lock_stb === 1'b1) seen = 1;
        end
        check_eq(name, int'(seen), 1);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin frame_tick = 1'b1; step(1); frame_tick = 1'b0; step(1); end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r0, l0, y0, s0, over_cyc;
        step(1);
        // Reset state while rst is held.
        check_eq("rst_chk_req", int'(chk_req), 0);
        check_eq("rst_piece_x", int'(piece_x), 10);
        check_eq("rst_piece_y", int'(piece_y), 1);
        check_eq("rst_lock_stb", int'(lock_stb), 0);
        check_eq("rst_game_over", int'(game_over), 0);
        rst = 1'b0;
        wait_spawn("first_spawn");

        // Thirty normal frame ticks give exactly one gravity check of (10,2,0).
        r0 = req_rises;
        tick_n(30);
        step(10);
        check_eq("grav_req_count", req_rises - r0, 1);
        check_eq("grav_req_x", last_x, 10);
        check_eq("grav_req_y", last_y, 2);
        check_eq("grav_req_rot", last_r, 0);
        check_eq("grav_piece_y", int'(piece_y), 2);

        // Rotate beats left when both arrive together.
        mv_left = 1'b1; mv_rot = 1'b1; step(1); mv_left = 1'b0; mv_rot = 1'b0;
        step(10);
        check_eq("rot_req_rot", last_r, 1);
        check_eq("rot_req_x", last_x, 10);
        check_eq("rot_piece_rot", int'(piece_rot), 1);
        check_eq("rot_piece_x", int'(piece_x), 10);

        // Blocked move is discarded without locking; controller keeps accepting moves.
        hit_mode = 1; l0 = lock_pulses;
        mv_right = 1'b1; step(1); mv_right = 1'b0;
        step(10);
        check_eq("blocked_piece_x", int'(piece_x), 10);
        check_eq("blocked_no_lock", lock_pulses - l0, 0);
        hit_mode = 0;
        mv_left = 1'b1; step(1); mv_left = 1'b0;
        step(10);
        check_eq("after_block_left_x", int'(piece_x), 9);

        // Hard drop from a fresh spawn: 19 commits to row 20, one lock, then respawn.
        do_reset();
        hit_mode = 2; auto_clr = 0;
        wait_spawn("drop_spawn");
        l0 = lock_pulses; y0 = y_steps;
        hard_drop = 1'b1; step(1); hard_drop = 1'b0;
        wait_lock("drop_lock");
        check_eq("drop_piece_y", int'(piece_y), 20);
        check_eq("drop_commits", y_steps - y0, 19);
        step(5);
        check_eq("drop_lock_once", lock_pulses - l0, 1);
        s0 = spawn_pulses;
        man_req++;
        wait_spawn("drop_respawn");
        check_eq("respawn_piece_y", int'(piece_y), 1);
        step(2);
        check_eq("respawn_once", spawn_pulses - s0, 1);

        // Gravity firing during clear wait is forgotten at spawn.
        hard_drop = 1'b1; step(1); hard_drop = 1'b0;
        wait_lock("wclr_lock");
        soft_drop = 1'b1; tick_n(3); soft_drop = 1'b0;
        man_req++;
        wait_spawn("wclr_spawn");
        r0 = req_rises;
        step(15);
        check_eq("wclr_no_grav_req", req_rises - r0, 0);
        check_eq("wclr_piece_y", int'(piece_y), 1);

        // Spawn collision ends the game; everything frozen until reset.
        hard_drop = 1'b1; step(1); hard_drop = 1'b0;
        wait_lock("over_lock");
        hit_mode = 1;
        man_req++;
        step(10);
        check_eq("over_flag", int'(game_over), 1);
        r0 = req_rises;
        mv_left = 1'b1; hard_drop = 1'b1; step(1); mv_left = 1'b0; hard_drop = 1'b0;
        tick_n(35);
        check_eq("over_sticky", int'(game_over), 1);
        check_eq("over_no_req", int'(chk_req), 0);
        check_eq("over_piece_y", int'(piece_y), 20);
        check_eq("over_req_count", req_rises - r0, 0);
        do_reset();
        check_eq("over_cleared", int'(game_over), 0);
        hit_mode = 0; auto_clr = 1;
        wait_spawn("post_over_spawn");

        // Randomised traffic against the model.
        hit_mode = 3; lat_max = 3; spur_en = 1; over_cyc = 0;
        for (int c = 0; c < 5000; c++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 63) == 0) soft_drop = ~soft_drop;
            mv_left   = ($urandom_range(0, 5) == 0);
            mv_right  = ($urandom_range(0, 5) == 0);
            mv_rot    = ($urandom_range(0, 7) == 0);
            hard_drop = ($urandom_range(0, 59) == 0);
            over_cyc  = (game_over === 1'b1) ? over_cyc + 1 : 0;
            rst       = ($urandom_range(0, 799) == 0) || (over_cyc > 12);
            step(1);
        end
        frame_tick = 0; mv_left = 0; mv_right = 0; mv_rot = 0; hard_drop = 0;
        soft_drop = 0; rst = 0; spur_en = 0;
        step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
